// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Holds the FSM state encoding and the default operand width.
package serial_sub_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit combinational full adder.
// Ports: i_a, i_b, i_cin in; o_s sum, o_cout carry out.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);

  logic p;

  assign p      = i_a ^ i_b;
  assign o_s    = p ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & p);

endmodule

// File: rtl/serial_sub8.sv
// Bit-serial subtractor: a - b as a + ~b + 1, LSB first, one bit/clk.
// Ports: i_clk, i_rst, i_start, i_a, i_b in; o_busy, o_done, o_diff, o_borrow out.
module serial_sub8
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-2:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             fa_s;
  logic             fa_cout;
  logic [WIDTH-1:0] nxt;

  full_adder u_fa (
    .i_a    (a_q[0]),
    .i_b    (b_q[0]),
    .i_cin  (carry),
    .o_s    (fa_s),
    .o_cout (fa_cout)
  );

  // Result so far with this cycle's sum bit entering at the MSB.
  assign nxt = {fa_s, res};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res      <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_diff   <= '0;
      o_borrow <= 1'b0;
    end else begin
      o_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (i_start) begin
            a_q    <= i_a;
            b_q    <= ~i_b;
            carry  <= 1'b1;
            cnt    <= '0;
            o_busy <= 1'b1;
            state  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          carry <= fa_cout;
          cnt   <= cnt + 1'b1;
          res   <= nxt[WIDTH-1:1];
          if (cnt == LAST) begin
            // No carry out of a + ~b + 1 means a < b.
            o_diff   <= nxt;
            o_borrow <= ~fa_cout;
            o_busy   <= 1'b0;
            o_done   <= 1'b1;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub8.sv
// Randomized self-checking bench for serial_sub8.
// Compares against a plain-arithmetic subtraction and timing model.
module tb_serial_sub8;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       borrow;

  logic       fa_a;
  logic       fa_b;
  logic       fa_cin;
  logic       fa_s;
  logic       fa_cout;

  int checks   = 0;
  int failures = 0;

  serial_sub8 #(.WIDTH(8)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_start  (start),
    .i_a      (a),
    .i_b      (b),
    .o_busy   (busy),
    .o_done   (done),
    .o_diff   (diff),
    .o_borrow (borrow)
  );

  full_adder u_fa (
    .i_a    (fa_a),
    .i_b    (fa_b),
    .i_cin  (fa_cin),
    .o_s    (fa_s),
    .o_cout (fa_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One full transaction: latency, busy width, result, hold.
  task automatic run_op(input logic [7:0] ta,
                        input logic [7:0] tb,
                        input string tag);
    int   lat;
    int   bcnt;
    bit   seen;
    logic [7:0] ed;
    logic       eb;
    ed = ta - tb;
    eb = (ta < tb);
    @(negedge clk);
    a = ta;
    b = tb;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    bcnt = busy ? 1 : 0;
    lat = 0;
    seen = 1'b0;
    for (int n = 1; n <= 20 && !seen; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        seen = 1'b1;
        lat = n;
      end else if (busy) begin
        bcnt++;
      end
    end
    check({tag, "_lat"}, lat, 8);
    check({tag, "_busy"}, bcnt, 8);
    check({tag, "_diff"}, diff, ed);
    check({tag, "_borrow"}, borrow, eb);
    @(posedge clk);
    #1;
    check({tag, "_done1"}, done, 0);
    check({tag, "_hold"}, diff, ed);
  endtask

  initial begin
    logic [2:0]  v;
    logic [1:0]  sm;
    int          ndone;
    int          last;
    logic [7:0]  cap_d;
    logic        cap_b;

    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    fa_a = 0;
    fa_b = 0;
    fa_cin = 0;

    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      {fa_a, fa_b, fa_cin} = v;
      #10;
      sm = 2'(fa_a) + 2'(fa_b) + 2'(fa_cin);
      check("fa", {fa_s, fa_cout}, {sm[0], sm[1]});
    end

    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_borrow", borrow, 0);
    @(negedge clk);
    rst = 1'b0;

    run_op(8'h05, 8'h03, "a05b03");
    run_op(8'h03, 8'h05, "a03b05");
    run_op(8'h00, 8'h00, "a00b00");
    run_op(8'hFF, 8'h01, "aFFb01");

    // Second start while shifting must be ignored.
    @(negedge clk);
    a = 8'h10;
    b = 8'h01;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    ndone = 0;
    cap_d = '0;
    cap_b = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      if (e == 3) begin
        @(negedge clk);
        a = 8'h00;
        b = 8'hFF;
        start = 1'b1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        ndone++;
        cap_d = diff;
        cap_b = borrow;
      end
    end
    check("ign_ndone", ndone, 1);
    check("ign_diff", cap_d, 8'h0F);
    check("ign_borrow", cap_b, 0);

    // Reset in the middle of an operation.
    @(negedge clk);
    a = 8'h33;
    b = 8'h11;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_diff", diff, 0);
    check("mrst_borrow", borrow, 0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("mrst_nodone", ndone, 0);
    check("mrst_diff2", diff, 0);
    run_op(8'h80, 8'h7F, "a80b7F");

    // Start held high: new operation every WIDTH+2 cycles.
    @(negedge clk);
    a = 8'h0A;
    b = 8'h0B;
    start = 1'b1;
    ndone = 0;
    last = 0;
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        check("hold_diff", diff, 8'hFF);
        check("hold_borrow", borrow, 1);
        if (last > 0) check("hold_period", e - last, 10);
        last = e;
      end
    end
    start = 1'b0;
    check("hold_ndone", ndone, 3);
    repeat (12) @(posedge clk);

    for (int r = 0; r < 20; r++) begin
      run_op(8'($urandom), 8'($urandom), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
